sipo_frame_rx: RTL and testbench

- Framed serial-in/parallel-out receiver: the serial-to-parallel counterpart of the team's parallel-load shift registers.
- Samples a serial line on a bit-enable strobe and checks start and stop framing.
- Assembles WIDTH data bits, LSB first, into a parallel word.
- Presents the word on a valid/ready output with frame-error and overrun flags; sits between a serial link and the parallel register bank.

---
 rtl/sipo_frame_rx.sv | 104 ++++++++++
 tb/tb_sipo_frame_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// Framed serial-in/parallel-out receiver: start bit, WIDTH data bits LSB first, stop bit.
// The assembled word is presented on a valid/ready output with frame-error and overrun pulses.
module sipo_frame_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   out_nxt;
    logic               valid_nxt;
    logic               ferr_nxt;
    logic               ovr_nxt;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        out_nxt   = out;
        valid_nxt = out_valid;
        ferr_nxt  = 1'b0;
        ovr_nxt   = 1'b0;

        // An accept drops valid unless a good stop bit reloads the word at the same edge.
        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end

        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!sin) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    shreg_nxt = {sin, shreg[WIDTH-1:1]};
                    if (cnt == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (sin) begin
                        out_nxt   = shreg;
                        valid_nxt = 1'b1;
                        ovr_nxt   = out_valid && !out_ready;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomised self-checking bench for sipo_frame_rx against a frame-level reference model.
// Directed scenarios first, then random frames with random gaps, stop errors and consumer stalls.
module tb_sipo_frame_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         sin;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_out   = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ferr  = 1'b0;
    logic         exp_ovr   = 1'b0;

    sipo_frame_rx #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .sin       (sin),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all(input logic busy_exp);
        check("out",       32'(out),       32'(exp_out));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("busy",      32'(busy),      32'(busy_exp));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun",   32'(overrun),   32'(exp_ovr));
    endtask

    // One clock: drive inputs, advance the model by the protocol rules, then compare after the edge.
    // rdy: 0/1 drive that level, 2 drive a random level.
    task automatic step(input logic en, input logic s, input bit is_stop,
                        input logic [W-1:0] word, input logic busy_exp, input int rdy);
        bit_en    = en;
        sin       = s;
        out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        if (en && is_stop && s) begin
            exp_ovr   = exp_valid && !out_ready;
            exp_out   = word;
            exp_valid = 1'b1;
        end else begin
            if (en && is_stop) exp_ferr = 1'b1;
            if (exp_valid && out_ready) exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(busy_exp);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit stop_ok, input int gap,
                              input int rdy_other, input int rdy_stop);
        logic b;
        for (int i = 0; i <= W + 1; i++) begin
            for (int g = 0; g < gap; g++) begin
                // Line value is irrelevant while bit_en is low.
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, d, i > 0, rdy_other);
            end
            if (i == 0)      b = 1'b0;
            else if (i <= W) b = d[i-1];
            else             b = stop_ok;
            step(1'b1, b, i == W + 1, d, i < W + 1, (i == W + 1) ? rdy_stop : rdy_other);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_out = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        check_all(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bit_en = 1'b0; sin = 1'b1; out_ready = 1'b0;
        #2;
        do_reset();

        // Idle line: ten strobes with sin=1 start nothing.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 0);

        // Single frame 1001, consumer stalled.
        send_frame(4'b1001, 1'b1, 0, 0, 0);
        check("frame1_word", 32'(out), 32'h9);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 0);
        check("frame1_held", 32'(out_valid), 32'h1);

        // Accept for one cycle, then frame 0101.
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1);
        check("accept_keeps_out", 32'(out), 32'h9);
        send_frame(4'b0101, 1'b1, 0, 0, 0);
        check("frame2_word", 32'(out), 32'h5);

        // Bad stop bit: error pulse, word untouched, back to idle.
        send_frame(4'b1101, 1'b0, 0, 0, 0);
        check("ferr_pulse", 32'(frame_err), 32'h1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 0);
        check("ferr_cleared", 32'(frame_err), 32'h0);

        // Overrun, then simultaneous load and accept.
        send_frame(4'b1101, 1'b1, 0, 0, 0);
        send_frame(4'b1011, 1'b1, 0, 0, 0);
        check("overrun_pulse", 32'(overrun), 32'h1);
        check("overrun_word", 32'(out), 32'hB);
        send_frame(4'b0110, 1'b1, 0, 0, 1);
        check("sim_accept_no_ovr", 32'(overrun), 32'h0);
        check("sim_accept_valid", 32'(out_valid), 32'h1);

        // Reset after start plus three data bits aborts the frame.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b1, 0);
        do_reset();
        send_frame(4'b0001, 1'b1, 0, 0, 0);
        check("post_reset_word", 32'(out), 32'h1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1);
        send_frame(4'b0001, 1'b1, 3, 0, 0);
        check("gapped_word", 32'(out), 32'h1);
        check("gapped_no_ovr", 32'(overrun), 32'h0);

        // Random traffic, including back-to-back frames.
        for (int k = 0; k < 60; k++) begin
            int idle_n;
            idle_n = $urandom_range(0, 3);
            for (int i = 0; i < idle_n; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, 1'b0, 2);
            send_frame(W'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 2), 2, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
